// File: rtl/program_counter_pkg.sv
// Shared definitions for the Hack program counter: widths, ROM depth, state encodings
// and the nand2-derived gate primitives that the datapath is built from.
package program_counter_pkg;

  localparam int PC_WIDTH     = 16;
  localparam int PC_ROM_DEPTH = 32768;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  function automatic logic nand2(input logic a, input logic b);
    return ~(a & b);
  endfunction

  function automatic logic not1(input logic a);
    return nand2(a, a);
  endfunction

  function automatic logic and2(input logic a, input logic b);
    return not1(nand2(a, b));
  endfunction

  function automatic logic or2(input logic a, input logic b);
    return nand2(not1(a), not1(b));
  endfunction

  // Classic four-nand exclusive-or.
  function automatic logic xor2(input logic a, input logic b);
    logic t;
    t = nand2(a, b);
    return nand2(nand2(a, t), nand2(b, t));
  endfunction

endpackage

// File: rtl/program_counter_incrementer.sv
// WIDTH-bit +1 as a ripple of half adders; the final carry-out is discarded so the
// result wraps modulo 2^WIDTH.
module pc_incrementer
  import program_counter_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] sum
);

  logic carry;

  always_comb begin
    sum   = '0;
    carry = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = xor2(a[i], carry);
      carry  = and2(a[i], carry);
    end
  end

endmodule

// File: rtl/program_counter.sv
// Hack CPU program counter: BOOT/RUN(/HALT) sequencing, stall > load > inc > hold select.
// Define PC_TRAP_EN to enable the ROM-range trap (HALT state, sticky overflow).
module program_counter
  import program_counter_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH
`ifdef PC_TRAP_EN
  , parameter int ROM_DEPTH = PC_ROM_DEPTH
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  input  logic             stall,
  output logic [WIDTH-1:0] out,
  output logic             pc_valid,
  output logic             overflow
);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] inc_val;
  logic             run, go, trap;
  logic             sel_load, sel_inc, sel_hold;

  pc_incrementer #(.WIDTH(WIDTH)) u_inc (
    .a   (out_q),
    .sum (inc_val)
  );

  always_comb begin
    out_d    = '0;
    state_d  = state_q;
    run      = (state_q == ST_RUN);
    go       = and2(run, not1(stall));
`ifdef PC_TRAP_EN
    trap     = and2(go, or2(and2(load, ({1'b0, in} >= (WIDTH+1)'(ROM_DEPTH))),
                            and2(and2(not1(load), inc), (out_q == WIDTH'(ROM_DEPTH - 1)))));
`else
    trap     = 1'b0;
`endif
    // A trapping edge selects hold, so out keeps its pre-trap value.
    sel_load = and2(and2(go, load), not1(trap));
    sel_inc  = and2(and2(go, and2(not1(load), inc)), not1(trap));
    sel_hold = not1(or2(sel_load, sel_inc));
    for (int i = 0; i < WIDTH; i++) begin
      out_d[i] = or2(or2(and2(sel_load, in[i]), and2(sel_inc, inc_val[i])),
                     and2(sel_hold, out_q[i]));
    end
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  state_d = trap ? ST_HALT : ST_RUN;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

`ifdef PC_TRAP_EN
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = or2(overflow_q, trap);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

  assign out      = out_q;
  assign pc_valid = run;

endmodule
